// File: rtl/fpu_vec_sequencer.sv
// Vector sequencer/checker for the FPU: fetches {A, B, op, expected} from a
// synchronous ROM, drives the FPU, waits LATENCY cycles and scores the result.
module fpu_vec_sequencer #(
  parameter int WIDTH        = 32,
  parameter int OPW          = 2,
  parameter int ADDR_W       = 4,
  parameter int NUM_VEC      = 16,
  parameter int LATENCY      = 1,
  parameter int TOL          = 0,
  parameter int STOP_ON_FAIL = 0,
  parameter int ERR_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [WIDTH-1:0]  vec_a,
  input  logic [WIDTH-1:0]  vec_b,
  input  logic [OPW-1:0]    vec_op,
  input  logic [WIDTH-1:0]  vec_exp,
  output logic [WIDTH-1:0]  dut_a,
  output logic [WIDTH-1:0]  dut_b,
  output logic [OPW-1:0]    dut_op,
  input  logic [WIDTH-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_idx,
  output logic              fail_valid
);

  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);
  localparam logic [WIDTH-1:0]  TOL_V    = WIDTH'(TOL);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_APPLY, S_WAIT, S_CHECK, S_FIN
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [WIDTH-1:0]  r_a, r_b, r_exp;
  logic [OPW-1:0]    r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [ERR_W-1:0]  r_err;
  logic [ADDR_W-1:0] r_fidx;
  logic              r_fv, r_busy, r_done, r_pass;
  logic              r_fin_hold;

  logic              w_sign_eq;
  logic [WIDTH-2:0]  w_mag_o, w_mag_e, w_diff;
  logic              w_match;

  // Tolerance applies to the magnitude field only; any sign difference
  // (including +0 vs -0) is a mismatch.
  always_comb begin
    w_sign_eq = (dut_out[WIDTH-1] == r_exp[WIDTH-1]);
    w_mag_o   = dut_out[WIDTH-2:0];
    w_mag_e   = r_exp[WIDTH-2:0];
    w_diff    = (w_mag_o >= w_mag_e) ? (w_mag_o - w_mag_e) : (w_mag_e - w_mag_o);
    w_match   = (dut_out == r_exp) || (w_sign_eq && ({1'b0, w_diff} <= TOL_V));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_exp      <= '0;
      r_cnt      <= '0;
      r_err      <= '0;
      r_fidx     <= '0;
      r_fv       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fin_hold <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // r_fin_hold masks start during the cycle in which done rises
          r_fin_hold <= 1'b0;
          if (start && !r_fin_hold) begin
            r_idx   <= '0;
            r_err   <= '0;
            r_fidx  <= '0;
            r_fv    <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_APPLY;
        S_APPLY: begin
          r_a     <= vec_a;
          r_b     <= vec_b;
          r_op    <= vec_op;
          r_exp   <= vec_exp;
          r_cnt   <= CNT_W'(LATENCY);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == CNT_W'(1)) r_state <= S_CHECK;
          else                    r_cnt   <= r_cnt - CNT_W'(1);
        end
        S_CHECK: begin
          if (!w_match) begin
            if (!(&r_err)) r_err <= r_err + ERR_W'(1);
            if (!r_fv) begin
              r_fidx <= r_idx;
              r_fv   <= 1'b1;
            end
          end
          if ((r_idx == LAST_IDX) || (!w_match && (STOP_ON_FAIL != 0))) begin
            r_state <= S_FIN;
          end else begin
            r_idx   <= r_idx + ADDR_W'(1);
            r_state <= S_FETCH;
          end
        end
        S_FIN: begin
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_pass     <= (r_err == '0);
          r_fin_hold <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vec_addr   = r_idx;
  assign dut_a      = r_a;
  assign dut_b      = r_b;
  assign dut_op     = r_op;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_idx   = r_fidx;
  assign fail_valid = r_fv;

endmodule

// File: tb/tb_fpu_vec_sequencer.sv
// Bench for fpu_vec_sequencer: shared vector ROM, behavioural FPU per instance,
// five parameter variants, operand and result scoreboards.
module tb_fpu_vec_sequencer;

  localparam int N = 16;

  typedef struct packed {
    logic [15:0] cyc;
    logic [7:0]  err;
    logic [3:0]  fidx;
    logic        fv;
    logic        pass;
    logic        busy;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] start;
  always #5 clk = ~clk;

  wire [3:0]  addr [5];
  wire [31:0] da [5];
  wire [31:0] db [5];
  wire [1:0]  dop [5];
  wire [4:0]  busy, done, pass, fv;
  wire [7:0]  errc [5];
  wire [3:0]  fidx [5];
  wire [1:0]  errc2;

  logic [31:0] ra [5];
  logic [31:0] rb [5];
  logic [31:0] re [5];
  logic [1:0]  rop [5];
  logic [31:0] fo [5];

  logic [31:0] rom_a [N];
  logic [31:0] rom_b [N];
  logic [31:0] rom_e [N];
  logic [1:0]  rom_op [N];

  logic [65:0] opq [$];
  res_t        resq [$];
  int total = 0;
  int bad   = 0;

  assign errc[3] = {6'b0, errc2};

  // 0: TOL=0, 1: TOL=1, 2: STOP_ON_FAIL, 3: ERR_W=2, 4: NUM_VEC=2
  for (genvar k = 0; k < 5; k++) begin : g
    if (k == 3) begin : sat
      fpu_vec_sequencer #(.ERR_W(2)) u (
        .clk(clk), .rst_n(rst_n), .start(start[k]), .vec_addr(addr[k]),
        .vec_a(ra[k]), .vec_b(rb[k]), .vec_op(rop[k]), .vec_exp(re[k]),
        .dut_a(da[k]), .dut_b(db[k]), .dut_op(dop[k]), .dut_out(fo[k]),
        .busy(busy[k]), .done(done[k]), .pass(pass[k]), .err_count(errc2),
        .fail_idx(fidx[k]), .fail_valid(fv[k]));
    end else begin : std
      fpu_vec_sequencer #(
        .NUM_VEC((k == 4) ? 2 : 16),
        .TOL((k == 1) ? 1 : 0),
        .STOP_ON_FAIL((k == 2) ? 1 : 0)
      ) u (
        .clk(clk), .rst_n(rst_n), .start(start[k]), .vec_addr(addr[k]),
        .vec_a(ra[k]), .vec_b(rb[k]), .vec_op(rop[k]), .vec_exp(re[k]),
        .dut_a(da[k]), .dut_b(db[k]), .dut_op(dop[k]), .dut_out(fo[k]),
        .busy(busy[k]), .done(done[k]), .pass(pass[k]), .err_count(errc[k]),
        .fail_idx(fidx[k]), .fail_valid(fv[k]));
    end
  end

  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r, input logic zs);
    real m, frac, rem;
    int e;
    int unsigned fr;
    logic s;
    if (r == 0.0) return {zs, 31'b0};
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    frac = (m - 1.0) * 8388608.0;
    fr   = $rtoi(frac);
    rem  = frac - real'(fr);
    if (rem > 0.5 || (rem == 0.5 && fr[0])) fr++;
    if (fr == 32'd8388608) begin fr = 0; e++; end
    return {s, e[7:0], fr[22:0]};
  endfunction

  function automatic logic [31:0] fpu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] op);
    real x, y;
    x = f2r(a);
    y = f2r(b);
    case (op)
      2'd0:    return r2f(x + y, 1'b0);
      2'd1:    return r2f(x - y, 1'b0);
      2'd2:    return r2f(x * y, a[31] ^ b[31]);
      default: return r2f((y == 0.0) ? 0.0 : x / y, a[31] ^ b[31]);
    endcase
  endfunction

  // Synchronous ROM (one-cycle read) and registered FPU, one per instance
  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) begin
      ra[k]  <= rom_a[addr[k]];
      rb[k]  <= rom_b[addr[k]];
      rop[k] <= rom_op[addr[k]];
      re[k]  <= rom_e[addr[k]];
      fo[k]  <= fpu(da[k], db[k], dop[k]);
    end
  end

  task automatic load_rom();
    for (int i = 0; i < N; i++) begin
      rom_a[i]  = r2f(real'(i + 1), 1'b0);
      rom_b[i]  = r2f(real'(i % 5 + 1), 1'b0);
      rom_op[i] = 2'(i);
      rom_e[i]  = fpu(rom_a[i], rom_b[i], rom_op[i]);
    end
    rom_a[0] = 32'h40000000; rom_b[0] = 32'h40400000; rom_op[0] = 2'd0; rom_e[0] = 32'h40A00000;
    rom_a[1] = 32'h40000000; rom_b[1] = 32'h40400000; rom_op[1] = 2'd3; rom_e[1] = 32'h3F2AAAAB;
    rom_a[5] = 32'h40000000; rom_b[5] = 32'h40400000; rom_op[5] = 2'd0; rom_e[5] = 32'h40A00000;
  endtask

  function automatic res_t mk(input int cyc, input int err, input int fi,
                              input logic v, input logic p);
    res_t r;
    r.cyc = 16'(cyc); r.err = 8'(err); r.fidx = 4'(fi);
    r.fv = v; r.pass = p; r.busy = 1'b0;
    return r;
  endfunction

  function automatic res_t obs(input int k, input int cyc);
    res_t r;
    r.cyc = 16'(cyc); r.err = errc[k]; r.fidx = fidx[k];
    r.fv = fv[k]; r.pass = pass[k]; r.busy = busy[k];
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("cyc=%0d err=%0d fidx=%0d fv=%b pass=%b busy=%b",
                     r.cyc, r.err, r.fidx, r.fv, r.pass, r.busy);
  endfunction

  // Runs one instance: pushes the operand tuples it should apply, pulses start,
  // pops/compares on every operand change, optionally pulses start at cycle bs.
  task automatic run(input int k, input int napply, input int bs, output int cyc);
    logic [65:0] last, cur, e;
    int maxa;
    for (int i = 0; i < napply; i++) opq.push_back({rom_a[i], rom_b[i], rom_op[i]});
    last = {da[k], db[k], dop[k]};
    maxa = 0;
    @(negedge clk); start[k] = 1'b1;
    @(negedge clk); start[k] = 1'b0;
    cyc = 0;
    while (done[k] !== 1'b1 && cyc < 400) begin
      if (int'(addr[k]) > maxa) maxa = int'(addr[k]);
      cur = {da[k], db[k], dop[k]};
      if (cur !== last) begin
        last = cur;
        total++;
        if (opq.size() == 0) begin
          bad++;
          $display("FAIL operands u%0d: got unexpected %h, want no further vector", k, cur);
        end else begin
          e = opq.pop_front();
          if (cur !== e) begin
            bad++;
            $display("FAIL operands u%0d: got %h want %h", k, cur, e);
          end
        end
      end
      start[k] = (cyc == bs);
      @(negedge clk); cyc++;
    end
    start[k] = 1'b0;
    total++;
    if (done[k] !== 1'b1) begin
      bad++;
      $display("FAIL timeout u%0d: got done=%b after %0d cycles, want 1", k, done[k], cyc);
    end
    total++;
    if (opq.size() != 0) begin
      bad++;
      $display("FAIL applied u%0d: got %0d vectors unapplied, want 0", k, opq.size());
    end
    opq.delete();
    total++;
    if (maxa > napply - 1) begin
      bad++;
      $display("FAIL addr_range u%0d: got max addr %0d, want <= %0d", k, maxa, napply - 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = '0;
    load_rom();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({addr[k], da[k], db[k], dop[k], busy[k], done[k], pass[k], errc[k], fidx[k], fv[k]} !== '0) begin
        bad++;
        $display("FAIL reset u%0d: got addr=%h a=%h b=%h op=%h busy=%b done=%b pass=%b err=%h fidx=%h fv=%b, want all 0",
                 k, addr[k], da[k], db[k], dop[k], busy[k], done[k], pass[k], errc[k], fidx[k], fv[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_two_vec();
    int cyc;
    res_t e;
    load_rom();
    resq.push_back(mk(9, 0, 0, 1'b0, 1'b1));
    run(4, 2, -1, cyc);
    e = resq.pop_front();
    total++;
    if (obs(4, cyc) !== e) begin
      bad++;
      $display("FAIL two_vec: got %s want %s", fmt(obs(4, cyc)), fmt(e));
    end
    total++;
    if ({da[4], db[4], dop[4]} !== {32'h40000000, 32'h40400000, 2'd3}) begin
      bad++;
      $display("FAIL two_vec_hold: got a=%h b=%h op=%0d want a=40000000 b=40400000 op=3",
               da[4], db[4], dop[4]);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    res_t e;
    resq.push_back(mk(9, 0, 0, 1'b0, 1'b1));
    run(4, 2, 3, cyc);
    e = resq.pop_front();
    total++;
    if (obs(4, cyc) !== e) begin
      bad++;
      $display("FAIL start_busy: got %s want %s", fmt(obs(4, cyc)), fmt(e));
    end
    start[4] = 1'b1;
    @(negedge clk); start[4] = 1'b0;
    total++;
    if ({busy[4], done[4], pass[4]} !== 3'b011) begin
      bad++;
      $display("FAIL start_done_cycle: got busy=%b done=%b pass=%b want busy=0 done=1 pass=1",
               busy[4], done[4], pass[4]);
    end
    resq.push_back(mk(9, 0, 0, 1'b0, 1'b1));
    run(4, 2, -1, cyc);
    e = resq.pop_front();
    total++;
    if (obs(4, cyc) !== e) begin
      bad++;
      $display("FAIL start_rerun: got %s want %s", fmt(obs(4, cyc)), fmt(e));
    end
  endtask

  task automatic test_corrupt_tol0();
    int cyc;
    res_t e;
    load_rom();
    rom_e[5] = 32'h40A00001;
    resq.push_back(mk(65, 1, 5, 1'b1, 1'b0));
    run(0, 16, -1, cyc);
    e = resq.pop_front();
    total++;
    if (obs(0, cyc) !== e) begin
      bad++;
      $display("FAIL corrupt_tol0: got %s want %s", fmt(obs(0, cyc)), fmt(e));
    end
  endtask

  task automatic test_tol1();
    int cyc;
    res_t e;
    load_rom();
    rom_e[5] = 32'h40A00001;
    resq.push_back(mk(65, 0, 0, 1'b0, 1'b1));
    run(1, 16, -1, cyc);
    e = resq.pop_front();
    total++;
    if (obs(1, cyc) !== e) begin
      bad++;
      $display("FAIL tol1: got %s want %s", fmt(obs(1, cyc)), fmt(e));
    end
  endtask

  task automatic test_sign_zero();
    int cyc;
    res_t e;
    load_rom();
    rom_a[0] = 32'h80000000; rom_b[0] = 32'h00000000; rom_op[0] = 2'd2; rom_e[0] = 32'h00000000;
    resq.push_back(mk(65, 1, 0, 1'b1, 1'b0));
    run(1, 16, -1, cyc);
    e = resq.pop_front();
    total++;
    if (obs(1, cyc) !== e) begin
      bad++;
      $display("FAIL sign_zero: got %s want %s", fmt(obs(1, cyc)), fmt(e));
    end
  endtask

  task automatic test_stop_on_fail();
    int cyc;
    res_t e;
    load_rom();
    rom_e[3] = rom_e[3] + 32'd1;
    rom_e[9] = rom_e[9] + 32'd1;
    resq.push_back(mk(17, 1, 3, 1'b1, 1'b0));
    run(2, 4, -1, cyc);
    e = resq.pop_front();
    total++;
    if (obs(2, cyc) !== e) begin
      bad++;
      $display("FAIL stop_on_fail: got %s want %s", fmt(obs(2, cyc)), fmt(e));
    end
  endtask

  task automatic test_err_sat();
    int cyc;
    res_t e;
    load_rom();
    for (int i = 0; i < N; i++) rom_e[i] = rom_e[i] + 32'd1;
    resq.push_back(mk(65, 3, 0, 1'b1, 1'b0));
    run(3, 16, -1, cyc);
    e = resq.pop_front();
    total++;
    if (obs(3, cyc) !== e) begin
      bad++;
      $display("FAIL err_sat: got %s want %s", fmt(obs(3, cyc)), fmt(e));
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    res_t e;
    load_rom();
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (30) @(negedge clk);
    total++;
    if ({busy[0], addr[0]} !== {1'b1, 4'd7}) begin
      bad++;
      $display("FAIL midrun_pos: got busy=%b addr=%0d want busy=1 addr=7", busy[0], addr[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({addr[0], da[0], db[0], dop[0], busy[0], done[0], pass[0], errc[0], fidx[0], fv[0]} !== '0) begin
      bad++;
      $display("FAIL midrun_reset: got addr=%h a=%h b=%h op=%h busy=%b done=%b err=%h fv=%b want all 0",
               addr[0], da[0], db[0], dop[0], busy[0], done[0], errc[0], fv[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    resq.push_back(mk(65, 0, 0, 1'b0, 1'b1));
    run(0, 16, -1, cyc);
    e = resq.pop_front();
    total++;
    if (obs(0, cyc) !== e) begin
      bad++;
      $display("FAIL after_reset_run: got %s want %s", fmt(obs(0, cyc)), fmt(e));
    end
  endtask

  initial begin
    test_reset();
    test_two_vec();
    test_start_ignored();
    test_corrupt_tol0();
    test_tol1();
    test_sign_zero();
    test_stop_on_fail();
    test_err_sat();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
